data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Responder end of the CPU load/store data port: accepts one memory request at a time over a valid/ready handshake, applies byte/halfword/word access rules, and returns read data or a store acknowledgement after a fixed, parameterised latency. It sits between the processor datapath (initiator) and a word-organised backing array held inside the block. It replaces the zero-latency `Mem` data path so multi-cycle memory behaviour can be exercised.

## Interface
- `WORD_WIDTH`, 32, data/address width
- `DEPTH_WORDS`, 1024, backing array size in 32-bit words
- `LATENCY`, 2, cycles from request acceptance to `rsp_valid`; legal range 1..15

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_addr`  in  32  byte address
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `req_unsigned`  in  1  loads: 1 zero-extend, 0 sign-extend (funct3[2])
- `req_we`  in  1  1 store, 0 load
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  initiator takes response
- `rsp_rdata`  out  32  load result, extended to 32 bits; 0 for stores and errors
- `rsp_err`  out  1  misaligned, illegal size, or out-of-range address

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch addr/size/unsigned/we/wdata, evaluate error, load latency counter; go to RESP if LATENCY==1, else BUSY.
- BUSY: counter decrements each cycle; go to RESP when the remaining count reaches zero. Requests are ignored (`req_ready`=0).
- RESP: `rsp_valid`=1, `rsp_rdata`/`rsp_err` stable until `rsp_ready`. On handshake, go to IDLE.
- Error check: halfword needs addr[0]=0; word needs addr[1:0]=0; size 11 always errors; addr[31:2] >= DEPTH_WORDS errors. Errored requests: no array write, `rsp_rdata`=0, `rsp_err`=1.
- Little-endian. Loads: select lane by addr[1:0], extend per `req_unsigned` (word ignores it). Stores: write only the addressed byte lanes, other bytes unchanged.
- Array write commits on the edge that enters RESP; array read is sampled on the same edge, so the response reflects the array state before that edge's write.
- Array contents are not cleared by reset.

## Timing
- Reset: state IDLE, counter 0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. `req_ready`=0 while `rst` is high, 1 in the first cycle after release.
- Acceptance at edge E -> `rsp_valid` high from edge E+LATENCY-1, i.e. visible LATENCY cycles after the accept cycle.
- Back-to-back: after response handshake at edge F, `req_ready` is high in the cycle after F; minimum spacing LATENCY+1 cycles per request.
- `rsp_ready` held low: RESP persists indefinitely, outputs stable.
- `rsp_ready` high before `rsp_valid`: no effect.
- Reset in BUSY or RESP: pending request dropped; a pending store not yet committed is not written.

## Structure
- Package `mem_pkg`: size codes (SIZE_BYTE/HWORD/WORD), state enum, WORD_WIDTH.
- Sub-module `mem_lane_align`: combinational lane select/extend for loads and byte-enable/data replication for stores, plus alignment error.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x100, load word at 0x100 -> `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` exactly LATENCY cycles after each accept.
- Byte/half extension: after the above, lb 0x103 -> 0xFFFFFFDE; lbu 0x103 -> 0x000000DE; lh 0x102 -> 0xFFFFDEAD; lhu 0x100 -> 0x0000BEEF.
- Partial store: sb 0x55 to 0x101 then lw 0x100 -> 0xDEAD55EF.
- Errors: lw 0x102, lh 0x101, size 11, lw 0x1000 (DEPTH 1024) -> `rsp_err`=1, rdata 0; following lw 0x100 unchanged.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_valid` and data stable, `req_ready`=0 throughout.
- Reset mid-store: accept sw 0x12345678 to 0x200 (LATENCY=3), assert `rst` the next cycle -> `rsp_valid` never asserts; later lw 0x200 returns prior contents.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// responder FSM states and the native word width.
package mem_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HWORD = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling for a 32-bit word array: picks and extends the
// addressed lane for loads, builds byte enables and replicated write data for
// stores, and flags misaligned or illegal-size accesses.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]            addr_lo,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [WORD_WIDTH-1:0] rword,
  output logic [WORD_WIDTH-1:0] load_data,
  output logic [WORD_WIDTH-1:0] store_data,
  output logic [3:0]            byte_en,
  output logic                  align_err
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes out of the read word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'b00:   byte_s = rword[7:0];
      2'b01:   byte_s = rword[15:8];
      2'b10:   byte_s = rword[23:16];
      2'b11:   byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rword[31:16];
    end else begin
      half_s = rword[15:0];
    end
  end

  // Size-dependent extension, byte enables, store replication and alignment.
  always_comb begin
    load_data  = {WORD_WIDTH{1'b0}};
    store_data = {WORD_WIDTH{1'b0}};
    byte_en    = 4'b0000;
    align_err  = 1'b0;
    case (size)
      SIZE_BYTE: begin
        load_data  = {{24{~is_unsigned & byte_s[7]}}, byte_s};
        store_data = {4{wdata[7:0]}};
        byte_en    = 4'b0001 << addr_lo;
        align_err  = 1'b0;
      end
      SIZE_HWORD: begin
        load_data  = {{16{~is_unsigned & half_s[15]}}, half_s};
        store_data = {2{wdata[15:0]}};
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        align_err  = addr_lo[0];
      end
      SIZE_WORD: begin
        load_data  = rword;
        store_data = wdata;
        byte_en    = 4'b1111;
        align_err  = (addr_lo != 2'b00);
      end
      default: begin
        align_err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data port. One request at a time is accepted,
// held for a fixed latency, then answered with load data or a store ack.
// The word array write and read both happen on the edge entering RESP, so a
// response always reflects the array contents from before that edge.
module data_mem_responder #(
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WORD_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic                  req_we,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);
  import mem_pkg::*;

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_e                state_r, state_nxt_s;
  logic [3:0]            cnt_r, cnt_nxt_s;
  logic                  accept_s, commit_s, wr_en_s;
  logic [WORD_WIDTH-1:0] addr_r, wdata_r;
  logic [1:0]            size_r;
  logic                  uns_r, we_r;

  logic [WORD_WIDTH-1:0] op_addr_s, op_wdata_s;
  logic [1:0]            op_size_s;
  logic                  op_uns_s, op_we_s;
  logic                  range_err_s, align_err_s, err_s;
  logic [IDX_W-1:0]      idx_s;
  logic [WORD_WIDTH-1:0] rword_s, load_data_s, store_data_s;
  logic [3:0]            byte_en_s;

  logic                  rsp_valid_r, rsp_err_r;
  logic [WORD_WIDTH-1:0] rsp_rdata_r;

  logic [WORD_WIDTH-1:0] mem_r [DEPTH_WORDS];

  assign req_ready = (state_r == ST_IDLE) && !rst;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  // With LATENCY==1 the commit edge is the accept edge, so the operation is
  // taken straight from the request inputs while idle, else from the latch.
  always_comb begin
    if (state_r == ST_IDLE) begin
      op_addr_s  = req_addr;
      op_size_s  = req_size;
      op_uns_s   = req_unsigned;
      op_we_s    = req_we;
      op_wdata_s = req_wdata;
    end else begin
      op_addr_s  = addr_r;
      op_size_s  = size_r;
      op_uns_s   = uns_r;
      op_we_s    = we_r;
      op_wdata_s = wdata_r;
    end
  end

  assign range_err_s = ({2'b00, op_addr_s[WORD_WIDTH-1:2]} >= WORD_WIDTH'(DEPTH_WORDS));
  assign err_s       = range_err_s | align_err_s;
  assign idx_s       = op_addr_s[IDX_W+1:2];
  assign rword_s     = mem_r[idx_s];
  assign wr_en_s     = commit_s & op_we_s & ~err_s & ~rst;

  mem_lane_align u_lane (
    .addr_lo     (op_addr_s[1:0]),
    .size        (op_size_s),
    .is_unsigned (op_uns_s),
    .wdata       (op_wdata_s),
    .rword       (rword_s),
    .load_data   (load_data_s),
    .store_data  (store_data_s),
    .byte_en     (byte_en_s),
    .align_err   (align_err_s)
  );

  // Next-state logic: accept in IDLE, count down in BUSY, hold in RESP.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_s = 1'b1;
          if (LAT_LOAD == 4'd0) begin
            state_nxt_s = ST_RESP;
            cnt_nxt_s   = 4'd0;
            commit_s    = 1'b1;
          end else begin
            state_nxt_s = ST_BUSY;
            cnt_nxt_s   = LAT_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_RESP;
          cnt_nxt_s   = 4'd0;
          commit_s    = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, countdown and request-capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= {WORD_WIDTH{1'b0}};
      wdata_r <= {WORD_WIDTH{1'b0}};
      size_r  <= 2'b00;
      uns_r   <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        size_r  <= req_size;
        uns_r   <= req_unsigned;
        we_r    <= req_we;
      end
    end
  end

  // Response registers: loaded on the commit edge, cleared after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {WORD_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (commit_s) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= (err_s || op_we_s) ? {WORD_WIDTH{1'b0}} : load_data_s;
      rsp_err_r   <= err_s;
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {WORD_WIDTH{1'b0}};
      rsp_err_r   <= 1'b0;
    end
  end

  // Backing array: byte-lane writes on commit; never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= store_data_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-addressed reference memory
// predicts each response, a monitor checks data, latency and stability.
module tb_data_mem_responder;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_unsigned, req_we;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   hold_bp = 1'b0;
  bit   seen = 1'b0;
  logic [31:0] held_d;
  logic        held_e;

  logic [31:0] exp_d_q[$];
  logic        exp_e_q[$];
  int          acc_q[$];
  logic [7:0]  mem_m [int unsigned];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.WORD_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_we(req_we), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: byte memory, little-endian, spec error rules.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] d, output logic e);
    int n;
    e = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
        (size == 2'd2 && addr[1:0] != 2'd0) || ((addr >> 2) >= DEPTH);
    d = 32'h0;
    if (e) return;
    n = 1 << size;
    if (we) begin
      for (int i = 0; i < n; i++) mem_m[addr + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++)
        d[8*i +: 8] = mem_m.exists(addr + i) ? mem_m[addr + i] : 8'h00;
      if (!uns && n < 4 && d[8*n-1])
        for (int i = n; i < 4; i++) d[8*i +: 8] = 8'hFF;
    end
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit chk, input logic [31:0] xd, input logic xe);
    logic [31:0] d;
    logic        e;
    int          w;
    model(we, size, uns, addr, wdata, d, e);
    if (chk) begin
      d = xd;
      e = xe;
    end
    exp_d_q.push_back(d);
    exp_e_q.push_back(e);
    @(posedge clk); #1;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1 for addr %h", addr);
      void'(exp_d_q.pop_back());
      void'(exp_e_q.pop_back());
      @(posedge clk); #1 req_valid = 1'b0;
      return;
    end
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_d_q.size() != 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (exp_d_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_d_q.size());
    end
  endtask

  // Initiator response-side backpressure, random unless held low.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = hold_bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency at first valid, stability while held, data at handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (rsp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held_d = rsp_rdata;
          held_e = rsp_err;
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0");
          end else begin
            check("latency", cyc - acc_q.pop_front(), LAT - 1);
          end
        end else begin
          check("stable_rdata", rsp_rdata, held_d);
          check("stable_err", {31'b0, rsp_err}, {31'b0, held_e});
        end
        check("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
        if (rsp_ready) begin
          seen = 1'b0;
          if (exp_d_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got response %h expected none", rsp_rdata);
          end else begin
            check("rsp_rdata", rsp_rdata, exp_d_q.pop_front());
            check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_e_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    int w;
    logic [31:0] a;
    logic [1:0]  sz;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_unsigned = 1'b0; req_we = 1'b0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Directed sequence from the access rules.
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1, 32'h000000DE, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h00000055, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h11111111, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 32'h100, 32'h22222222, 1'b1, 32'h0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0);

    // Fill the random working region and the reset-test word.
    for (int i = 1; i < 16; i++)
      issue(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4*i), $urandom, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0);
    wait_drain();

    // Backpressure: response held for five cycles.
    @(negedge clk) hold_bp = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0);
    w = 0;
    while (!rsp_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    end
    hold_bp = 1'b0;
    wait_drain();

    // Reset one cycle after accepting a store: no response, no write.
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
      check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("after_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("after_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("after_rst_rsp_rdata", rsp_rdata, 32'd0);
    check("after_rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    repeat (4) @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      a  = 32'h100 + 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + 32'($urandom_range(0, 4095));
        1:       sz = 2'd3;
        default: ;
      endcase
      if (sz == 2'd1 && $urandom_range(0, 1) == 0) a[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            1'b0, 32'h0, 1'b0);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
